adc_capture_core: RTL and testbench
===================================

Name: adc_capture_core

Overview:
- ADC capture-and-replay core.
- Captures a block of 18-bit samples into on-chip memory, either live ADC samples or an internal self-test ramp.
- Replays the memory as fixed-length packets on an 18-bit data bus with a valid strobe and forwarded read clock.
- Top-level digital block behind the chip pads; configuration arrives as static register inputs from the register file.

Parameters:
- DW, 18, sample/data width.
- DEPTH, 1728, capture memory words; must be a multiple of 1728.
- AW, 11, address width, ceil(log2(DEPTH)).

Ports:
- clk  in  1  core clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_clk_en  in  1  1 = core runs; 0 = FSM, counters and outputs hold.
- cfg_sw_rstn  in  1  synchronous soft reset, active low; same effect as rst.
- cfg_self_test  in  1  1 = capture internal ramp; 0 = capture adc_in.
- cfg_pkt_len  in  2  packet length: 0=216, 1=432, 2=864, 3=1728 words.
- cfg_pkt_gap  in  4  idle cycles (valid low) between packets.
- capture_start  in  1  pulse: capture a new block, then replay it.
- capture_again  in  1  pulse: replay the stored block without recapture.
- adc_in  in  DW  live ADC sample, accepted every WRITE cycle.
- adc_data  out  DW  replayed sample.
- adc_data_valid  out  1  adc_data qualifier.
- clk_rd  out  1  forwarded read clock = cfg_clk_en & ~clk.
- mem_addr  out  AW  current memory read/write address.
- curr_sta  out  2  FSM state.
- fast_rd_done  out  1  one-cycle pulse on the last replay address.

Behaviour:
- Reset (rst or cfg_sw_rstn=0):
  - curr_sta=IDLE, mem_addr=0, adc_data=0, adc_data_valid=0, fast_rd_done=0, gap counter=0.
  - Memory contents are not cleared.
  - Reset mid-operation aborts immediately.
- FSM encoding: IDLE=0, READ=1, GAP=2, WRITE=3.
- IDLE:
  - capture_start → WRITE, with mem_addr=0.
  - Otherwise capture_again → READ, with mem_addr=0.
  - If both are high in the same cycle, start wins.
- WRITE:
  - Each cycle writes word[mem_addr] = cfg_self_test ? mem_addr zero-extended to DW : adc_in.
  - mem_addr increments each cycle.
  - After writing DEPTH-1: mem_addr←0, → READ.
  - Start/again pulses are ignored.
- READ:
  - Each cycle issues a synchronous memory read at mem_addr and increments mem_addr and the packet word counter.
  - adc_data/adc_data_valid are registered: they reflect the address issued one cycle earlier.
  - When the packet counter reaches L-1, where L = 216<<cfg_pkt_len:
    - if cfg_pkt_gap≠0: → GAP, packet counter ←0;
    - if cfg_pkt_gap=0: stay in READ (back-to-back packets).
  - When mem_addr = DEPTH-1 is issued:
    - fast_rd_done=1 for that single cycle, with curr_sta still READ;
    - next state is IDLE and mem_addr←0.
    - End-of-memory takes priority over GAP.
  - Start/again pulses during READ/GAP are ignored.
- GAP:
  - Counts cfg_pkt_gap cycles with no read issued, so valid drops for exactly cfg_pkt_gap cycles.
  - Then → READ.
- Output timing:
  - adc_data_valid=1 exactly in the cycles following a READ cycle.
  - The final word appears in the first IDLE cycle.
  - Total valid words per replay = DEPTH.
- Config changes:
  - cfg_pkt_len and cfg_pkt_gap are sampled at packet boundaries only.
  - cfg_self_test is sampled on entry to WRITE.
- cfg_clk_en=0: all registers hold their values; clk_rd held low.
- Memory: single-port DEPTH×DW, synchronous read, registered output.

Test Plan:
- Reset then idle: rst high 20 ns, then low with no start → curr_sta=0, mem_addr=0, valid=0, clk_rd toggles inverted from clk.
- Self-test capture and replay:
  - Setup: cfg_self_test=1, cfg_pkt_len=1, cfg_pkt_gap=4, one-cycle capture_start.
  - Required: WRITE for 1728 cycles, then 4 packets of 432 valid words each carrying the ramp 0..1727.
  - Required: exactly 4-cycle valid gaps between packets.
  - Required: fast_rd_done pulses once with curr_sta=1 and mem_addr=1727, then IDLE.
- Replay again:
  - Stimulus: after done, pulse capture_again.
  - Required: identical 1728-word stream with no WRITE phase.
  - Required: a second fast_rd_done, after which the bench stops.
- Zero gap, 1728 length: cfg_pkt_gap=0, cfg_pkt_len=3 → 1728 contiguous valid cycles, never entering GAP.
- Live capture: cfg_self_test=0 with adc_in driven as 18'h3FFFF-index → replay returns exactly those words in order.
- Abort and simultaneous requests:
  - Soft reset mid-READ: assert cfg_sw_rstn=0 → next cycle IDLE with valid=0, and the following capture_again replays from address 0.
  - start+again together in IDLE → WRITE.

Source files
------------

// File: rtl/adc_capture_core.sv
// ADC capture-and-replay core: fills a sample memory from the ADC or a self-test
// ramp, then streams it back as fixed-length packets separated by idle gaps.
module adc_capture_core #(
    parameter int DW    = 18,
    parameter int DEPTH = 1728,
    parameter int AW    = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_clk_en,
    input  logic          cfg_sw_rstn,
    input  logic          cfg_self_test,
    input  logic [1:0]    cfg_pkt_len,
    input  logic [3:0]    cfg_pkt_gap,
    input  logic          capture_start,
    input  logic          capture_again,
    input  logic [DW-1:0] adc_in,
    output logic [DW-1:0] adc_data,
    output logic          adc_data_valid,
    output logic          clk_rd,
    output logic [AW-1:0] mem_addr,
    output logic [1:0]    curr_sta,
    output logic          fast_rd_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        GAP   = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] PRE_LAST  = AW'(DEPTH - 2);

    state_t        state;
    logic [AW-1:0] pkt_cnt;
    logic [AW-1:0] pkt_last;
    logic [3:0]    gap_cnt;
    logic [3:0]    gap_q;
    logic [1:0]    len_q;
    logic          self_test_q;
    logic          write_en;
    logic [DW-1:0] mem [DEPTH];

    assign curr_sta = state;
    assign clk_rd   = cfg_clk_en & ~clk;
    assign pkt_last = AW'((216 << len_q) - 1);
    assign write_en = cfg_clk_en && cfg_sw_rstn && (state == WRITE);

    // NOTE: the sample memory has no reset, so captured data survives any reset and maps onto block RAM.
    always_ff @(posedge clk) begin
        if (write_en)
            mem[mem_addr] <= self_test_q ? DW'(mem_addr) : adc_in;
    end

    // NOTE: every register in this block uses <= so all next-state terms see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            mem_addr       <= '0;
            pkt_cnt        <= '0;
            gap_cnt        <= '0;
            gap_q          <= '0;
            len_q          <= '0;
            self_test_q    <= 1'b0;
            adc_data       <= '0;
            adc_data_valid <= 1'b0;
            fast_rd_done   <= 1'b0;
        end else if (cfg_clk_en) begin
            if (!cfg_sw_rstn) begin
                state          <= IDLE;
                mem_addr       <= '0;
                pkt_cnt        <= '0;
                gap_cnt        <= '0;
                gap_q          <= '0;
                len_q          <= '0;
                self_test_q    <= 1'b0;
                adc_data       <= '0;
                adc_data_valid <= 1'b0;
                fast_rd_done   <= 1'b0;
            end else begin
                adc_data_valid <= (state == READ);
                // Packets always end on multiples of 216, so DEPTH-2 is always followed by a read of DEPTH-1.
                fast_rd_done   <= (state == READ) && (mem_addr == PRE_LAST);
                case (state)
                    IDLE: begin
                        if (capture_start) begin
                            state       <= WRITE;
                            mem_addr    <= '0;
                            self_test_q <= cfg_self_test;
                        end else if (capture_again) begin
                            state    <= READ;
                            mem_addr <= '0;
                            pkt_cnt  <= '0;
                            len_q    <= cfg_pkt_len;
                        end
                    end
                    WRITE: begin
                        if (mem_addr == LAST_ADDR) begin
                            state    <= READ;
                            mem_addr <= '0;
                            pkt_cnt  <= '0;
                            len_q    <= cfg_pkt_len;
                        end else begin
                            mem_addr <= mem_addr + 1'b1;
                        end
                    end
                    READ: begin
                        adc_data <= mem[mem_addr];
                        if (mem_addr == LAST_ADDR) begin
                            state    <= IDLE;
                            mem_addr <= '0;
                            pkt_cnt  <= '0;
                        end else begin
                            mem_addr <= mem_addr + 1'b1;
                            if (pkt_cnt == pkt_last) begin
                                pkt_cnt <= '0;
                                len_q   <= cfg_pkt_len;
                                gap_q   <= cfg_pkt_gap;
                                gap_cnt <= '0;
                                if (cfg_pkt_gap != 4'd0)
                                    state <= GAP;
                            end else begin
                                pkt_cnt <= pkt_cnt + 1'b1;
                            end
                        end
                    end
                    GAP: begin
                        if (gap_cnt == gap_q - 4'd1) begin
                            state   <= READ;
                            gap_cnt <= '0;
                        end else begin
                            gap_cnt <= gap_cnt + 4'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_capture_core.sv
// Directed bench for adc_capture_core: self-test and live capture, replay with and
// without gaps, soft-reset abort, clock-enable hold and start/again priority.
module tb_adc_capture_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_clk_en = 1'b1;
    logic        cfg_sw_rstn = 1'b1;
    logic        cfg_self_test = 1'b0;
    logic [1:0]  cfg_pkt_len = 2'd0;
    logic [3:0]  cfg_pkt_gap = 4'd0;
    logic        capture_start = 1'b0;
    logic        capture_again = 1'b0;
    logic [17:0] adc_in = '0;
    logic [17:0] adc_data;
    logic        adc_data_valid;
    logic        clk_rd;
    logic [10:0] mem_addr;
    logic [1:0]  curr_sta;
    logic        fast_rd_done;

    int n_checks = 0;
    int n_errors = 0;

    adc_capture_core dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_clk_en     (cfg_clk_en),
        .cfg_sw_rstn    (cfg_sw_rstn),
        .cfg_self_test  (cfg_self_test),
        .cfg_pkt_len    (cfg_pkt_len),
        .cfg_pkt_gap    (cfg_pkt_gap),
        .capture_start  (capture_start),
        .capture_again  (capture_again),
        .adc_in         (adc_in),
        .adc_data       (adc_data),
        .adc_data_valid (adc_data_valid),
        .clk_rd         (clk_rd),
        .mem_addr       (mem_addr),
        .curr_sta       (curr_sta),
        .fast_rd_done   (fast_rd_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Pulses start/again, then watches one complete capture/replay until valid drops after done.
    // kind 0 expects the ramp idx, kind 1 expects 18'h3FFFF-idx (what adc_in is driven with).
    task automatic run_replay(input string tag, input bit do_start, input bit do_again,
                              input int kind, input int exp_gap, input int exp_run,
                              input int exp_writes);
        int words = 0, bad_words = 0, writes = 0, gap_cycles = 0;
        int runs = 0, bad_runs = 0, bad_gaps = 0, run_len = 0, idle_len = 0;
        int dones = 0, bad_done = 0, after_done_sta = -1, cyc = 0;
        bit prev_valid = 0, seen_run = 0, finished = 0;
        logic [17:0] exp_w;
        @(negedge clk);
        capture_start = do_start;
        capture_again = do_again;
        while (!finished && cyc < 8000) begin
            @(negedge clk);
            capture_start = 1'b0;
            capture_again = 1'b0;
            cyc++;
            if (curr_sta == 2'd3) begin
                adc_in = 18'h3FFFF - 18'(writes);
                writes++;
            end
            if (adc_data_valid) begin
                exp_w = (kind == 1) ? 18'h3FFFF - 18'(words) : 18'(words);
                if (adc_data !== exp_w) bad_words++;
                words++;
                if (!prev_valid && seen_run && idle_len != exp_gap) bad_gaps++;
                run_len++;
                idle_len = 0;
                seen_run = 1;
            end else begin
                if (prev_valid) begin
                    runs++;
                    if (run_len != exp_run) bad_runs++;
                    run_len = 0;
                    if (dones > 0) finished = 1;
                end
                idle_len++;
            end
            if (curr_sta == 2'd2) gap_cycles++;
            if (fast_rd_done) begin
                dones++;
                if (curr_sta != 2'd1 || mem_addr != 11'd1727) bad_done++;
            end else if (dones == 1 && after_done_sta < 0) begin
                after_done_sta = curr_sta;
            end
            prev_valid = adc_data_valid;
        end
        check({tag, "_finished"}, finished, 1);
        check({tag, "_words"}, words, 1728);
        check({tag, "_bad_words"}, bad_words, 0);
        check({tag, "_write_cycles"}, writes, exp_writes);
        check({tag, "_runs"}, runs, 1728 / exp_run);
        check({tag, "_bad_runs"}, bad_runs, 0);
        check({tag, "_bad_gaps"}, bad_gaps, 0);
        check({tag, "_gap_cycles"}, gap_cycles, (1728 / exp_run - 1) * exp_gap);
        check({tag, "_done_pulses"}, dones, 1);
        check({tag, "_done_ctx"}, bad_done, 0);
        check({tag, "_sta_after_done"}, after_done_sta, 0);
    endtask

    initial begin
        // Reset then idle
        #20 rst = 1'b0;
        @(negedge clk);
        check("rst_sta", curr_sta, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_valid", adc_data_valid, 0);
        check("rst_data", adc_data, 0);
        check("rst_done", fast_rd_done, 0);
        check("clk_rd_clk_low", clk_rd, 1);
        @(posedge clk);
        #1 check("clk_rd_clk_high", clk_rd, 0);

        // Clock enable low: start pulse ignored, clk_rd held low
        @(negedge clk);
        cfg_clk_en = 1'b0;
        capture_start = 1'b1;
        @(negedge clk);
        capture_start = 1'b0;
        check("clken_clk_rd", clk_rd, 0);
        @(negedge clk);
        check("clken_hold_sta", curr_sta, 0);
        cfg_clk_en = 1'b1;

        // Self-test capture, 432-word packets, 4-cycle gaps
        cfg_self_test = 1'b1;
        cfg_pkt_len = 2'd1;
        cfg_pkt_gap = 4'd4;
        run_replay("selftest", 1, 0, 0, 4, 432, 1728);

        // Replay the stored ramp without recapture
        run_replay("again", 0, 1, 0, 4, 432, 0);

        // Zero gap, full-length packet
        cfg_pkt_gap = 4'd0;
        cfg_pkt_len = 2'd3;
        run_replay("nogap", 0, 1, 0, 0, 1728, 0);

        // Soft reset mid-READ, then replay from address 0
        cfg_pkt_gap = 4'd2;
        cfg_pkt_len = 2'd0;
        @(negedge clk);
        capture_again = 1'b1;
        @(negedge clk);
        capture_again = 1'b0;
        repeat (100) @(negedge clk);
        check("srst_busy_sta", curr_sta, 1);
        cfg_sw_rstn = 1'b0;
        @(negedge clk);
        check("srst_sta", curr_sta, 0);
        check("srst_valid", adc_data_valid, 0);
        check("srst_addr", mem_addr, 0);
        cfg_sw_rstn = 1'b1;
        run_replay("after_srst", 0, 1, 0, 2, 216, 0);

        // Live capture with start and again together: start wins
        cfg_self_test = 1'b0;
        cfg_pkt_len = 2'd1;
        cfg_pkt_gap = 4'd4;
        run_replay("live", 1, 1, 1, 4, 432, 1728);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
